// File: rtl/frame_buffer_arbiter.sv
// ============================================================================
// frame_buffer_arbiter: shares one single-port cell RAM among display fetch,
// brush writer and sand sim, and schedules one sim generation per frame.
// Optional feature macro: ARB_OVERRUN_COUNT_EN (adds overrun_count_o).
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  pixel_tick_i,
  input  logic                  video_en_i,
  input  logic [ADDR_WIDTH-1:0] pixel_i,
  input  logic                  vsync_i,
  output logic [DATA_WIDTH-1:0] disp_data_o,
  output logic                  disp_valid_o,
  input  logic                  brush_req_i,
  input  logic [ADDR_WIDTH-1:0] brush_addr_i,
  input  logic [DATA_WIDTH-1:0] brush_wdata_i,
  output logic                  brush_gnt_o,
  input  logic                  sim_req_i,
  input  logic                  sim_we_i,
  input  logic [ADDR_WIDTH-1:0] sim_addr_i,
  input  logic [DATA_WIDTH-1:0] sim_wdata_i,
  output logic                  sim_gnt_o,
  output logic [DATA_WIDTH-1:0] sim_rdata_o,
  output logic                  sim_rvalid_o,
  input  logic                  sim_enable_i,
  output logic                  sim_start_o,
  input  logic                  sim_done_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
`ifdef ARB_OVERRUN_COUNT_EN
  ,
  output logic [7:0]            overrun_count_o
`endif
);

  localparam logic [1:0] c_TAG_NONE = 2'd0;
  localparam logic [1:0] c_TAG_DISP = 2'd1;
  localparam logic [1:0] c_TAG_SIM  = 2'd2;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic                  w_disp_win;
  logic                  w_brush_win;
  logic                  w_sim_win;
  logic                  w_disp_valid;
  logic                  w_sim_rvalid;
  logic                  w_frame_tick;
  logic                  w_overrun;
  logic [0:0]            w_state_next;
  logic [0:0]            r_state;
  logic                  r_vsync_q;
  logic [1:0]            r_tag1;
  logic [1:0]            r_tag2;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_we;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [DATA_WIDTH-1:0] r_disp_data;
  logic [DATA_WIDTH-1:0] r_sim_rdata;

  always_comb begin
    w_disp_win  = pixel_tick_i & video_en_i;
    w_brush_win = brush_req_i & ~w_disp_win;
    w_sim_win   = sim_req_i & ~w_disp_win & ~brush_req_i;
  end

  assign brush_gnt_o = w_brush_win & ~reset_i;
  assign sim_gnt_o   = w_sim_win & ~reset_i;

  // The winner is registered onto the RAM port; the tag follows the read two stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_tag1      <= c_TAG_NONE;
      r_tag2      <= c_TAG_NONE;
    end else begin
      r_tag2   <= r_tag1;
      r_tag1   <= c_TAG_NONE;
      r_ram_we <= 1'b0;
      if (w_disp_win) begin
        r_ram_addr <= pixel_i;
        r_tag1     <= c_TAG_DISP;
      end else if (w_brush_win) begin
        r_ram_addr  <= brush_addr_i;
        r_ram_we    <= 1'b1;
        r_ram_wdata <= brush_wdata_i;
      end else if (w_sim_win) begin
        r_ram_addr  <= sim_addr_i;
        r_ram_we    <= sim_we_i;
        r_ram_wdata <= sim_wdata_i;
        r_tag1      <= sim_we_i ? c_TAG_NONE : c_TAG_SIM;
      end
    end
  end

  assign ram_addr_o  = r_ram_addr;
  assign ram_we_o    = r_ram_we;
  assign ram_wdata_o = r_ram_wdata;

  assign w_disp_valid = (r_tag2 == c_TAG_DISP) & ~reset_i;
  assign w_sim_rvalid = (r_tag2 == c_TAG_SIM) & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_disp_data <= '0;
      r_sim_rdata <= '0;
    end else begin
      if (w_disp_valid) r_disp_data <= ram_rdata_i;
      if (w_sim_rvalid) r_sim_rdata <= ram_rdata_i;
    end
  end

  assign disp_valid_o = w_disp_valid;
  assign disp_data_o  = w_disp_valid ? ram_rdata_i : r_disp_data;
  assign sim_rvalid_o = w_sim_rvalid;
  assign sim_rdata_o  = w_sim_rvalid ? ram_rdata_i : r_sim_rdata;

  assign w_frame_tick = vsync_i & ~r_vsync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= c_ST_IDLE;
      r_vsync_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_vsync_q <= vsync_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_frame_tick & sim_enable_i) w_state_next = c_ST_RUN;
      c_ST_RUN:  if (sim_done_i & ~w_frame_tick)  w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // A tick coinciding with done restarts immediately and is not an overrun.
  always_comb begin
    sim_start_o = 1'b0;
    w_overrun   = 1'b0;
    if (!reset_i) begin
      case (r_state)
        c_ST_IDLE: sim_start_o = w_frame_tick & sim_enable_i;
        c_ST_RUN: begin
          sim_start_o = w_frame_tick & sim_done_i;
          w_overrun   = w_frame_tick & ~sim_done_i;
        end
        default: sim_start_o = 1'b0;
      endcase
    end
  end

`ifdef ARB_OVERRUN_COUNT_EN
  logic [7:0] r_overrun_count;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_overrun_count <= 8'd0;
    else if (w_overrun && r_overrun_count != 8'hFF)
      r_overrun_count <= r_overrun_count + 8'd1;
  end

  assign overrun_count_o = r_overrun_count;
`else
  logic w_overrun_unused;
  assign w_overrun_unused = w_overrun;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: arbitration vector table plus
// hand-written sequences for read latency, scheduler and reset corner cases.
`default_nettype none

module tb_frame_buffer_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pixel_tick_i, video_en_i, vsync_i;
  logic [18:0] pixel_i;
  logic [1:0]  disp_data_o;
  logic        disp_valid_o;
  logic        brush_req_i;
  logic [18:0] brush_addr_i;
  logic [1:0]  brush_wdata_i;
  logic        brush_gnt_o;
  logic        sim_req_i, sim_we_i;
  logic [18:0] sim_addr_i;
  logic [1:0]  sim_wdata_i;
  logic        sim_gnt_o;
  logic [1:0]  sim_rdata_o;
  logic        sim_rvalid_o;
  logic        sim_enable_i, sim_start_o, sim_done_i;
  logic [18:0] ram_addr_o;
  logic        ram_we_o;
  logic [1:0]  ram_wdata_o;
  logic [1:0]  ram_rdata_i;
`ifdef ARB_OVERRUN_COUNT_EN
  logic [7:0]  overrun_count_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  frame_buffer_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pixel_tick_i(pixel_tick_i), .video_en_i(video_en_i), .pixel_i(pixel_i),
    .vsync_i(vsync_i), .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o),
    .brush_req_i(brush_req_i), .brush_addr_i(brush_addr_i),
    .brush_wdata_i(brush_wdata_i), .brush_gnt_o(brush_gnt_o),
    .sim_req_i(sim_req_i), .sim_we_i(sim_we_i), .sim_addr_i(sim_addr_i),
    .sim_wdata_i(sim_wdata_i), .sim_gnt_o(sim_gnt_o), .sim_rdata_o(sim_rdata_o),
    .sim_rvalid_o(sim_rvalid_o), .sim_enable_i(sim_enable_i),
    .sim_start_o(sim_start_o), .sim_done_i(sim_done_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
`ifdef ARB_OVERRUN_COUNT_EN
    , .overrun_count_o(overrun_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Synchronous single-port RAM model with one cycle of read latency.
  logic [1:0] mem [0:1023];
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_addr_o[9:0]] <= ram_wdata_o;
    ram_rdata_i <= mem[ram_addr_o[9:0]];
  end

  typedef struct {
    logic tick, ven, breq, sreq, swe;
    logic exp_bgnt, exp_sgnt, exp_we;
    logic [18:0] exp_addr;
    logic [1:0]  exp_wdata;
  } vec_t;
  vec_t vecs [8];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    pixel_tick_i = 0; video_en_i = 0; brush_req_i = 0;
    sim_req_i = 0; sim_we_i = 0; sim_done_i = 0;
  endtask

  task automatic vs_rise(input string name, input logic en, input logic done, input logic exp_start);
    sim_enable_i = en; vsync_i = 0; sim_done_i = 0;
    step();
    vsync_i = 1; sim_done_i = done;
    #1;
    check(name, sim_start_o, exp_start);
    step();
    check({name, "_pulse_end"}, sim_start_o, 0);
    vsync_i = 0; sim_done_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    mem[5] = 2'b11;
    mem[9] = 2'b01;

    // tick ven breq sreq swe | bgnt sgnt we addr wdata
    vecs[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 19'd20, 2'd0};
    vecs[1] = '{1, 0, 1, 1, 0, 1, 0, 1, 19'd30, 2'd1};
    vecs[2] = '{0, 1, 0, 1, 1, 0, 1, 1, 19'd40, 2'd2};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 19'd40, 2'd0};
    vecs[4] = '{1, 0, 0, 0, 0, 0, 0, 0, 19'd40, 2'd0};
    vecs[5] = '{0, 0, 0, 1, 0, 0, 1, 0, 19'd40, 2'd0};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 0, 0, 19'd20, 2'd0};
    vecs[7] = '{0, 0, 1, 0, 0, 1, 0, 1, 19'd30, 2'd1};

    clear_inputs();
    reset_i = 1; vsync_i = 0; sim_enable_i = 0;
    pixel_i = 0; brush_addr_i = 0; brush_wdata_i = 0; sim_addr_i = 0; sim_wdata_i = 0;
    step(); step();
    check("init_ram_we", ram_we_o, 0);
    check("init_ram_addr", ram_addr_o, 0);
    check("init_start", sim_start_o, 0);
    reset_i = 0;
    step();

    pixel_i = 19'd20; brush_addr_i = 19'd30; brush_wdata_i = 2'd1;
    sim_addr_i = 19'd40; sim_wdata_i = 2'd2;
    foreach (vecs[i]) begin
      pixel_tick_i = vecs[i].tick; video_en_i = vecs[i].ven;
      brush_req_i = vecs[i].breq; sim_req_i = vecs[i].sreq; sim_we_i = vecs[i].swe;
      #1;
      check($sformatf("vec%0d_bgnt", i), brush_gnt_o, vecs[i].exp_bgnt);
      check($sformatf("vec%0d_sgnt", i), sim_gnt_o, vecs[i].exp_sgnt);
      step();
      check($sformatf("vec%0d_we", i), ram_we_o, vecs[i].exp_we);
      check($sformatf("vec%0d_addr", i), ram_addr_o, vecs[i].exp_addr);
      if (vecs[i].exp_we) check($sformatf("vec%0d_wdata", i), ram_wdata_o, vecs[i].exp_wdata);
    end
    clear_inputs();
    step(); step(); step();

    // Display fetch of a preloaded cell
    pixel_tick_i = 1; video_en_i = 1; pixel_i = 19'd5;
    step();
    pixel_tick_i = 0;
    check("disp_ram_addr", ram_addr_o, 5);
    check("disp_ram_we", ram_we_o, 0);
    check("disp_valid_early", disp_valid_o, 0);
    step();
    check("disp_valid", disp_valid_o, 1);
    check("disp_data", disp_data_o, 3);
    step();
    check("disp_valid_drop", disp_valid_o, 0);
    check("disp_data_hold", disp_data_o, 3);

    // Three-way contention
    pixel_tick_i = 1; video_en_i = 1; pixel_i = 19'd20;
    brush_req_i = 1; brush_addr_i = 19'd7; brush_wdata_i = 2'd1;
    sim_req_i = 1; sim_we_i = 0; sim_addr_i = 19'd9;
    #1;
    check("c3_T_bgnt", brush_gnt_o, 0);
    check("c3_T_sgnt", sim_gnt_o, 0);
    step();
    pixel_tick_i = 0;
    #1;
    check("c3_T1_bgnt", brush_gnt_o, 1);
    check("c3_T1_sgnt", sim_gnt_o, 0);
    step();
    brush_req_i = 0;
    #1;
    check("c3_T2_sgnt", sim_gnt_o, 1);
    check("c3_T2_ram_addr", ram_addr_o, 7);
    check("c3_T2_ram_we", ram_we_o, 1);
    check("c3_T2_disp_valid", disp_valid_o, 1);
    step();
    sim_req_i = 0;
    check("c3_T3_ram_addr", ram_addr_o, 9);
    check("c3_T3_rvalid", sim_rvalid_o, 0);
    step();
    check("c3_T4_rvalid", sim_rvalid_o, 1);
    check("c3_T4_rdata", sim_rdata_o, 1);
    step();

    // Sim write then read-back
    sim_req_i = 1; sim_we_i = 1; sim_addr_i = 19'd100; sim_wdata_i = 2'd2;
    #1;
    check("sw_gnt", sim_gnt_o, 1);
    step();
    sim_we_i = 0;
    #1;
    check("sr_gnt", sim_gnt_o, 1);
    check("sw_ram_we", ram_we_o, 1);
    step();
    sim_req_i = 0;
    check("sr_ram_addr", ram_addr_o, 100);
    check("sr_rvalid_early", sim_rvalid_o, 0);
    step();
    check("sr_rvalid", sim_rvalid_o, 1);
    check("sr_rdata", sim_rdata_o, 2);
    step();
    check("sr_rvalid_drop", sim_rvalid_o, 0);
    check("sr_rdata_hold", sim_rdata_o, 2);

    // Scheduler
    vs_rise("first_start", 1, 0, 1);
    vs_rise("overrun_no_start", 1, 0, 0);
`ifdef ARB_OVERRUN_COUNT_EN
    check("overrun_count1", overrun_count_o, 1);
`endif
    vs_rise("restart_done_tick", 1, 1, 1);
    sim_done_i = 1;
    step();
    sim_done_i = 0;
    step();
    sim_done_i = 1;
    #1;
    check("done_in_idle", sim_start_o, 0);
    step();
    sim_done_i = 0;
    vs_rise("paused_no_start", 0, 0, 0);
    vs_rise("idle_start", 1, 0, 1);
    vs_rise("run_no_abort", 0, 0, 0);
`ifdef ARB_OVERRUN_COUNT_EN
    check("overrun_count2", overrun_count_o, 2);
`endif

    // Reset mid-traffic while the scheduler is running
    pixel_tick_i = 1; video_en_i = 1; pixel_i = 19'd5;
    brush_req_i = 1; sim_req_i = 1; sim_enable_i = 1;
    step();
    vsync_i = 1; reset_i = 1;
    step(); step();
    check("rst_ram_addr", ram_addr_o, 0);
    check("rst_ram_we", ram_we_o, 0);
    check("rst_ram_wdata", ram_wdata_o, 0);
    check("rst_bgnt", brush_gnt_o, 0);
    check("rst_sgnt", sim_gnt_o, 0);
    check("rst_disp_valid", disp_valid_o, 0);
    check("rst_disp_data", disp_data_o, 0);
    check("rst_sim_rvalid", sim_rvalid_o, 0);
    check("rst_sim_rdata", sim_rdata_o, 0);
    check("rst_start", sim_start_o, 0);
`ifdef ARB_OVERRUN_COUNT_EN
    check("rst_overrun_count", overrun_count_o, 0);
`endif
    clear_inputs();
    vsync_i = 0; reset_i = 0;
    step();
    vs_rise("post_reset_idle", 1, 0, 1);

    // Reset kills an in-flight sim read
    sim_req_i = 1; sim_we_i = 0; sim_addr_i = 19'd9;
    #1;
    check("kill_gnt", sim_gnt_o, 1);
    step();
    sim_req_i = 0; reset_i = 1;
    check("kill_rvalid_T1", sim_rvalid_o, 0);
    step();
    reset_i = 0;
    check("kill_rvalid_T2", sim_rvalid_o, 0);
    step();
    check("kill_rvalid_T3", sim_rvalid_o, 0);
    step();
    check("kill_rvalid_T4", sim_rvalid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
